// File: rtl/mode_pulse_pkg.sv
// Shared definitions for the mode pulse transmitter and its receiver:
// FSM state encoding, default frame timing and the receiver decode point.
package mode_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int DEF_FRAME_LEN    = 1050000;
  localparam int DEF_HIGH_SHORT   = 50500;
  localparam int DEF_HIGH_LONG    = 95000;
  localparam int DEF_BURST_FRAMES = 5;

  // The receiver samples the line this many cycles after each rising edge.
  localparam int DECODE_THRESHOLD = 75000;

  // Frame counter never narrower than this, so the register map stays stable.
  localparam int MIN_FRAME_CNT_W  = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_frame_timer.sv
// Per-frame cycle counter. Counts 0..FRAME_LEN-1 while running and flags
// the last high cycle, the cycle before frame end and the frame end itself.
module pulse_frame_timer
  import mode_pulse_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_high_len,
  output logic             o_high_end,
  output logic             o_frame_pre_end,
  output logic             o_frame_end
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_frame_end;

  assign w_frame_end     = (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign o_frame_end     = w_frame_end;
  assign o_frame_pre_end = (r_cnt == CNT_W'(FRAME_LEN - 2));
  assign o_high_end      = (r_cnt == (i_high_len - CNT_W'(1)));

  // Cycle counter: held at zero outside a burst, cleared at every frame end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_run || w_frame_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mode_pulse_transmitter.sv
// Sends BURST_FRAMES back-to-back frames per accepted request; each frame is
// high for HIGH_SHORT or HIGH_LONG cycles (latched mode) then low to FRAME_LEN.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no burst, request may be accepted
// HIGH    | high part of a frame, PULSE_OUT=1
// LOW     | low part of a frame, PULSE_OUT=0
module mode_pulse_transmitter
  import mode_pulse_pkg::*;
#(
  parameter int FRAME_LEN                = DEF_FRAME_LEN,
  parameter int HIGH_SHORT               = DEF_HIGH_SHORT,
  parameter int HIGH_LONG                = DEF_HIGH_LONG,
  parameter int BURST_FRAMES             = DEF_BURST_FRAMES,
  parameter bit ENFORCE_DECODE_THRESHOLD = 1'b1
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic REQ_VALID,
  input  logic REQ_MODE,
  output logic REQ_READY,
  input  logic ABORT,
  output logic PULSE_OUT,
  output logic BUSY,
  output logic FRAME_DONE,
  output logic BURST_DONE
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int FRM_W = max_int(MIN_FRAME_CNT_W, $clog2(BURST_FRAMES + 1));

  if (!(HIGH_SHORT > 0 && HIGH_SHORT < HIGH_LONG && HIGH_LONG < FRAME_LEN && BURST_FRAMES > 0))
  begin : g_bad_timing
    $error("mode_pulse_transmitter: need 0 < HIGH_SHORT < HIGH_LONG < FRAME_LEN, BURST_FRAMES > 0");
  end

  if (ENFORCE_DECODE_THRESHOLD &&
      !(HIGH_SHORT < DECODE_THRESHOLD && DECODE_THRESHOLD < HIGH_LONG))
  begin : g_bad_threshold
    $error("mode_pulse_transmitter: high times must straddle the receiver decode threshold");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [FRM_W-1:0] r_frame;
  logic             r_mode;
  logic             r_ready;
  logic             r_pulse;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_burst_done;

  logic             w_accept;
  logic             w_last_frame;
  logic             w_timer_run;
  logic             w_strobe_next;
  logic [CNT_W-1:0] w_high_len;
  logic             w_high_end;
  logic             w_frame_pre_end;
  logic             w_frame_end;

  // ABORT wins over a pending request even when REQ_READY is already high.
  assign w_accept      = (r_state == ST_IDLE) && r_ready && REQ_VALID && !ABORT;
  assign w_last_frame  = (r_frame == FRM_W'(BURST_FRAMES - 1));
  assign w_high_len    = r_mode ? CNT_W'(HIGH_LONG) : CNT_W'(HIGH_SHORT);
  assign w_timer_run   = (r_state != ST_IDLE) && (w_next_state != ST_IDLE);
  // Strobes are registered, so they are launched one cycle ahead of frame end.
  assign w_strobe_next = (r_state != ST_IDLE) && !ABORT && w_frame_pre_end;

  pulse_frame_timer #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_timer (
    .i_clk           (CLOCK_50),
    .i_rst           (RESET),
    .i_run           (w_timer_run),
    .i_high_len      (w_high_len),
    .o_high_end      (w_high_end),
    .o_frame_pre_end (w_frame_pre_end),
    .o_frame_end     (w_frame_end)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_HIGH;
      end
      ST_HIGH: begin
        if (ABORT)           w_next_state = ST_IDLE;
        else if (w_high_end) w_next_state = ST_LOW;
      end
      ST_LOW: begin
        if (ABORT)            w_next_state = ST_IDLE;
        else if (w_frame_end) w_next_state = w_last_frame ? ST_IDLE : ST_HIGH;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Frame index within the burst and the mode latched at acceptance.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_frame <= '0;
      r_mode  <= 1'b0;
    end else begin
      if (w_next_state == ST_IDLE) begin
        r_frame <= '0;
      end else if (r_state == ST_LOW && w_frame_end) begin
        r_frame <= r_frame + FRM_W'(1);
      end
      if (w_accept) r_mode <= REQ_MODE;
    end
  end

  // Registered outputs, all derived from the upcoming state.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_ready      <= 1'b0;
      r_pulse      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_ready      <= (w_next_state == ST_IDLE) && !ABORT;
      r_pulse      <= (w_next_state == ST_HIGH);
      r_busy       <= (w_next_state != ST_IDLE);
      r_frame_done <= w_strobe_next;
      r_burst_done <= w_strobe_next && w_last_frame;
    end
  end

  assign REQ_READY  = r_ready;
  assign PULSE_OUT  = r_pulse;
  assign BUSY       = r_busy;
  assign FRAME_DONE = r_frame_done;
  assign BURST_DONE = r_burst_done;

endmodule

// File: tb/tb_mode_pulse_transmitter.sv
// Bench for mode_pulse_transmitter with a short frame geometry. A reference
// model tracks "cycles since acceptance" and derives every output from it.
module tb_mode_pulse_transmitter;

  localparam int FL = 20;
  localparam int HS = 5;
  localparam int HL = 12;
  localparam int BF = 3;

  logic CLOCK_50  = 1'b0;
  logic RESET     = 1'b1;
  logic REQ_VALID = 1'b0;
  logic REQ_MODE  = 1'b0;
  logic ABORT     = 1'b0;
  logic REQ_READY, PULSE_OUT, BUSY, FRAME_DONE, BURST_DONE;

  int n_checks = 0;
  int n_errors = 0;

  mode_pulse_transmitter #(
    .FRAME_LEN                (FL),
    .HIGH_SHORT               (HS),
    .HIGH_LONG                (HL),
    .BURST_FRAMES             (BF),
    .ENFORCE_DECODE_THRESHOLD (1'b0)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .REQ_VALID  (REQ_VALID),
    .REQ_MODE   (REQ_MODE),
    .REQ_READY  (REQ_READY),
    .ABORT      (ABORT),
    .PULSE_OUT  (PULSE_OUT),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .BURST_DONE (BURST_DONE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m_k is the 1-based cycle count since acceptance.
  bit m_active = 1'b0;
  bit m_ready  = 1'b0;
  bit m_mode   = 1'b0;
  int m_k      = 0;

  always @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      m_active = 1'b0;
      m_ready  = 1'b0;
      m_mode   = 1'b0;
      m_k      = 0;
    end else begin
      if (m_active) begin
        if (ABORT || m_k == BF * FL) m_active = 1'b0;
        else                         m_k++;
      end else if (m_ready && REQ_VALID && !ABORT) begin
        m_active = 1'b1;
        m_k      = 1;
        m_mode   = REQ_MODE;
      end
      m_ready = !m_active && !ABORT;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit chk_en  = 1'b0;
  int cnt_high = 0;
  int cnt_fd   = 0;
  int cnt_bd   = 0;
  int cnt_rdy  = 0;

  always @(negedge CLOCK_50) begin
    bit e_pulse, e_fd, e_bd;
    int h;
    if (chk_en && !RESET) begin
      h       = m_mode ? HL : HS;
      e_pulse = m_active && (((m_k - 1) % FL) < h);
      e_fd    = m_active && ((m_k % FL) == 0);
      e_bd    = m_active && (m_k == BF * FL);
      chk("pulse",      32'(PULSE_OUT),  32'(e_pulse));
      chk("busy",       32'(BUSY),       32'(m_active));
      chk("frame_done", 32'(FRAME_DONE), 32'(e_fd));
      chk("burst_done", 32'(BURST_DONE), 32'(e_bd));
      chk("ready",      32'(REQ_READY),  32'(m_ready));
      cnt_high += int'(PULSE_OUT);
      cnt_fd   += int'(FRAME_DONE);
      cnt_bd   += int'(BURST_DONE);
      cnt_rdy  += int'(REQ_READY);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (BUSY && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pulse"}, 32'(PULSE_OUT),  32'd0);
    chk({tag, "_busy"},  32'(BUSY),       32'd0);
    chk({tag, "_ready"}, 32'(REQ_READY),  32'd0);
    chk({tag, "_fd"},    32'(FRAME_DONE), 32'd0);
    chk({tag, "_bd"},    32'(BURST_DONE), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_high, s_fd, s_bd, s_rdy;

    tick(2);
    check_reset_values("rst");

    RESET = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("ready_after_release", 32'(REQ_READY), 32'd1);

    // Single mode-0 request: 5 high / 15 low, three frames, one burst strobe.
    REQ_VALID = 1'b1; REQ_MODE = 1'b0;
    tick();
    REQ_VALID = 1'b0;
    chk("m0_first_high", 32'(PULSE_OUT), 32'd1);
    s_high = cnt_high; s_fd = cnt_fd; s_bd = cnt_bd;
    tick(60);
    chk("m0_high_cycles", 32'(cnt_high - s_high), 32'(BF * HS));
    chk("m0_frame_dones", 32'(cnt_fd - s_fd), 32'(BF));
    chk("m0_burst_dones", 32'(cnt_bd - s_bd), 32'd1);
    chk("m0_idle_after",  32'(BUSY), 32'd0);

    // Mode-1 request with REQ_MODE/REQ_VALID churning during the burst.
    tick(2);
    REQ_VALID = 1'b1; REQ_MODE = 1'b1;
    tick();
    s_high = cnt_high;
    for (int i = 0; i < 60; i++) begin
      REQ_MODE  = 1'($urandom);
      REQ_VALID = 1'($urandom);
      tick();
    end
    REQ_VALID = 1'b0;
    chk("m1_high_cycles", 32'(cnt_high - s_high), 32'(BF * HL));
    wait_idle(200);

    // REQ_VALID held: back-to-back bursts with one IDLE cycle in between.
    tick(2);
    REQ_VALID = 1'b1; REQ_MODE = 1'b0;
    tick();
    s_bd = cnt_bd; s_rdy = cnt_rdy;
    tick(129);
    chk("held_burst_dones", 32'(cnt_bd - s_bd), 32'd2);
    chk("held_ready_cycles", 32'(cnt_rdy - s_rdy), 32'd2);
    REQ_VALID = 1'b0;
    wait_idle(200);

    // ABORT with a pending request in IDLE blocks acceptance.
    tick(2);
    REQ_VALID = 1'b1; ABORT = 1'b1;
    tick();
    chk("abort_idle_busy", 32'(BUSY), 32'd0);
    REQ_VALID = 1'b0; ABORT = 1'b0;
    tick(2);

    // ABORT in the 7th cycle of frame 2 (mode 1, so the line is high then).
    REQ_VALID = 1'b1; REQ_MODE = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    s_fd = cnt_fd; s_bd = cnt_bd;
    tick(26);
    chk("abort_pre_pulse", 32'(PULSE_OUT), 32'd1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_pulse", 32'(PULSE_OUT), 32'd0);
    chk("abort_busy",  32'(BUSY), 32'd0);
    tick(40);
    chk("abort_frame_dones", 32'(cnt_fd - s_fd), 32'd1);
    chk("abort_burst_dones", 32'(cnt_bd - s_bd), 32'd0);

    // Asynchronous reset in the middle of HIGH.
    REQ_VALID = 1'b1; REQ_MODE = 1'b0;
    tick();
    REQ_VALID = 1'b0;
    tick(2);
    chk("rst_mid_pre_pulse", 32'(PULSE_OUT), 32'd1);
    #1;
    RESET = 1'b1;
    #1;
    check_reset_values("async_rst");
    tick(3);
    RESET = 1'b0;
    tick();
    chk("ready_after_rerelease", 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    s_high = cnt_high; s_fd = cnt_fd; s_bd = cnt_bd;
    tick(60);
    chk("post_rst_high_cycles", 32'(cnt_high - s_high), 32'(BF * HS));
    chk("post_rst_frame_dones", 32'(cnt_fd - s_fd), 32'(BF));
    chk("post_rst_burst_dones", 32'(cnt_bd - s_bd), 32'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      REQ_VALID = ($urandom_range(0, 3) == 0);
      REQ_MODE  = 1'($urandom);
      ABORT     = ($urandom_range(0, 59) == 0);
      tick();
    end
    REQ_VALID = 1'b0;
    ABORT     = 1'b0;
    wait_idle(200);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
